// File: rtl/down_counter_timer_if.sv
`timescale 1ns/1ps
// Control/status bundle for the loadable down-counter timer.
// The master drives the start/stop/mode controls; the timer (slave) returns count and status.
interface down_counter_timer_if #(
   parameter int COUNTER_WIDTH = 8
);
   logic                     en;
   logic                     start;
   logic                     stop;
   logic                     periodic;
   logic [COUNTER_WIDTH-1:0] load_val;
   logic [COUNTER_WIDTH-1:0] cntr_o;
   logic                     tc_o;
   logic                     busy_o;
   logic                     done_o;

   modport master (
      output en, start, stop, periodic, load_val,
      input  cntr_o, tc_o, busy_o, done_o
   );

   modport slave (
      input  en, start, stop, periodic, load_val,
      output cntr_o, tc_o, busy_o, done_o
   );
endinterface

// File: rtl/down_counter_timer.sv
`timescale 1ns/1ps
// Loadable down-counter timer with one-shot and auto-reload modes.
// Emits a single-cycle terminal-count pulse on the enabled edge that finds the count at zero.
module down_counter_timer #(
   parameter int COUNTER_WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   down_counter_timer_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                   state_reg;
   logic [COUNTER_WIDTH-1:0] cntr_reg;
   logic [COUNTER_WIDTH-1:0] reload_reg;
   logic                     mode_reg;
   logic                     tc_reg;
   logic                     busy_reg;
   logic                     done_reg;

   // busy/done are written alongside every state change so they always reflect the new state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         cntr_reg   <= '0;
         reload_reg <= '0;
         mode_reg   <= 1'b0;
         tc_reg     <= 1'b0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         tc_reg <= 1'b0;
         if (bus.stop) begin
            // Abort keeps the count where it stopped.
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
         end else if (bus.start) begin
            cntr_reg   <= bus.load_val;
            reload_reg <= bus.load_val;
            mode_reg   <= bus.periodic;
            state_reg  <= RUN;
            busy_reg   <= 1'b1;
            done_reg   <= 1'b0;
         end else if (state_reg == RUN && bus.en) begin
            if (cntr_reg != '0) begin
               cntr_reg <= cntr_reg - COUNTER_WIDTH'(1);
            end else begin
               tc_reg <= 1'b1;
               if (mode_reg) begin
                  cntr_reg <= reload_reg;
               end else begin
                  state_reg <= DONE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
               end
            end
         end
      end
   end

   assign bus.cntr_o = cntr_reg;
   assign bus.tc_o   = tc_reg;
   assign bus.busy_o = busy_reg;
   assign bus.done_o = done_reg;
endmodule

// File: tb/tb_down_counter_timer.sv
`timescale 1ns/1ps
// Randomised and directed checks of down_counter_timer against a cycles-remaining model.
// The model tracks how many enabled edges remain until the next expiry and derives the visible count from that.
module tb_down_counter_timer;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   down_counter_timer_if #(.COUNTER_WIDTH(W)) bus ();

   down_counter_timer #(.COUNTER_WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   int m_left   = 0;   // enabled edges until the next terminal count
   int m_reload = 0;
   int m_shown  = 0;   // expected cntr_o
   bit m_run    = 0;
   bit m_done   = 0;
   bit m_per    = 0;
   bit m_tc     = 0;

   function automatic void model_reset();
      m_left = 0; m_reload = 0; m_shown = 0;
      m_run = 0; m_done = 0; m_per = 0; m_tc = 0;
   endfunction

   function automatic void model_edge();
      m_tc = 0;
      if (rst) begin
         model_reset();
      end else if (bus.stop) begin
         m_run  = 0;
         m_done = 0;
      end else if (bus.start) begin
         m_run    = 1;
         m_done   = 0;
         m_per    = bus.periodic;
         m_reload = int'(bus.load_val);
         m_left   = m_reload + 1;
         m_shown  = m_reload;
      end else if (m_run && bus.en) begin
         m_left = m_left - 1;
         if (m_left == 0) begin
            m_tc = 1;
            if (m_per) begin
               m_left = m_reload + 1;
            end else begin
               m_run  = 0;
               m_done = 1;
            end
         end
         m_shown = m_run ? m_left - 1 : 0;
      end
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_idle_inputs();
      bus.en = 1'b1; bus.start = 1'b0; bus.stop = 1'b0;
      bus.periodic = 1'b0; bus.load_val = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_idle_inputs();
      step();
      step();
      vectors++;
      if ({bus.cntr_o, bus.tc_o, bus.busy_o, bus.done_o} !== {8'd0, 3'b000}) begin
         miscompares++;
         $display("FAIL reset: got cntr=%0d tc=%b busy=%b done=%b, want all zero",
                  bus.cntr_o, bus.tc_o, bus.busy_o, bus.done_o);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_one_shot();
      int want_cntr;
      bus.load_val = 8'd5; bus.periodic = 1'b0; bus.en = 1'b1;
      for (int e = 0; e < 8; e++) begin
         bus.start = (e == 0);
         step();
         bus.start = 1'b0;
         want_cntr = (e <= 5) ? 5 - e : 0;
         vectors++;
         if ({bus.cntr_o, bus.tc_o, bus.busy_o, bus.done_o} !==
             {W'(want_cntr), (e == 6), (e <= 5), (e >= 6)}) begin
            miscompares++;
            $display("FAIL one_shot E%0d: got cntr=%0d tc=%b busy=%b done=%b, want cntr=%0d tc=%b busy=%b done=%b",
                     e, bus.cntr_o, bus.tc_o, bus.busy_o, bus.done_o, want_cntr, (e == 6), (e <= 5), (e >= 6));
         end
      end
      bus.stop = 1'b1; step(); bus.stop = 1'b0;
   endtask

   task automatic test_periodic();
      int pulses = 0;
      bus.load_val = 8'd3; bus.periodic = 1'b1; bus.en = 1'b1; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int e = 1; e <= 40; e++) begin
         step();
         if (bus.tc_o === 1'b1) pulses++;
         vectors++;
         if ({bus.cntr_o, bus.tc_o, bus.busy_o, bus.done_o} !== {W'(m_shown), m_tc, m_run, m_done}) begin
            miscompares++;
            $display("FAIL periodic E%0d: got cntr=%0d tc=%b busy=%b done=%b, want cntr=%0d tc=%b busy=%b done=%b",
                     e, bus.cntr_o, bus.tc_o, bus.busy_o, bus.done_o, m_shown, m_tc, m_run, m_done);
         end
      end
      vectors++;
      if (pulses != 10) begin
         miscompares++;
         $display("FAIL periodic_pulses: got %0d pulses, want 10", pulses);
      end
      bus.stop = 1'b1; step(); bus.stop = 1'b0;
   endtask

   task automatic test_pause();
      int tc_edge = -1;
      bus.load_val = 8'd4; bus.periodic = 1'b0; bus.en = 1'b1; bus.start = 1'b1;
      for (int e = 0; e <= 11; e++) begin
         bus.en = !(e >= 3 && e <= 5);
         step();
         bus.start = 1'b0;
         if (bus.tc_o === 1'b1 && tc_edge < 0) tc_edge = e;
         vectors++;
         if ({bus.cntr_o, bus.tc_o, bus.busy_o, bus.done_o} !== {W'(m_shown), m_tc, m_run, m_done}) begin
            miscompares++;
            $display("FAIL pause E%0d: got cntr=%0d tc=%b busy=%b done=%b, want cntr=%0d tc=%b busy=%b done=%b",
                     e, bus.cntr_o, bus.tc_o, bus.busy_o, bus.done_o, m_shown, m_tc, m_run, m_done);
         end
      end
      // Ungated expiry would be at E5; three paused edges push it to E8.
      vectors++;
      if (tc_edge != 8) begin
         miscompares++;
         $display("FAIL pause_delay: got tc at E%0d, want E8", tc_edge);
      end
      bus.en = 1'b1;
      bus.stop = 1'b1; step(); bus.stop = 1'b0;
   endtask

   task automatic test_edges();
      int pulses = 0;
      int tc_edge = -1;
      bus.load_val = 8'd0; bus.periodic = 1'b1; bus.en = 1'b1; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int e = 1; e <= 20; e++) begin
         step();
         if (bus.tc_o === 1'b1) pulses++;
      end
      vectors++;
      if (pulses != 20) begin
         miscompares++;
         $display("FAIL zero_periodic: got %0d pulses in 20 cycles, want 20", pulses);
      end
      bus.stop = 1'b1; step(); bus.stop = 1'b0;

      bus.load_val = 8'd255; bus.periodic = 1'b0; bus.start = 1'b1;
      for (int e = 0; e <= 260; e++) begin
         step();
         bus.start = 1'b0;
         if (bus.tc_o === 1'b1 && tc_edge < 0) tc_edge = e;
         vectors++;
         if ({bus.cntr_o, bus.tc_o, bus.busy_o, bus.done_o} !== {W'(m_shown), m_tc, m_run, m_done}) begin
            miscompares++;
            $display("FAIL max_load E%0d: got cntr=%0d tc=%b busy=%b done=%b, want cntr=%0d tc=%b busy=%b done=%b",
                     e, bus.cntr_o, bus.tc_o, bus.busy_o, bus.done_o, m_shown, m_tc, m_run, m_done);
         end
      end
      vectors++;
      if (tc_edge != 256) begin
         miscompares++;
         $display("FAIL max_load_tc: got tc at E%0d, want E256", tc_edge);
      end
   endtask

   task automatic test_control();
      // Leaves DONE from the previous task: start+stop together must land in IDLE.
      bus.load_val = 8'd9; bus.periodic = 1'b0; bus.en = 1'b1; bus.start = 1'b1;
      for (int e = 0; e < 3; e++) begin
         step();
         bus.start = 1'b0;
      end
      bus.start = 1'b1; bus.stop = 1'b1; bus.load_val = 8'd50;
      step();
      bus.start = 1'b0; bus.stop = 1'b0;
      step(); step(); step();
      vectors++;
      if ({bus.cntr_o, bus.tc_o, bus.busy_o, bus.done_o} !== {8'd7, 3'b000}) begin
         miscompares++;
         $display("FAIL stop_start: got cntr=%0d tc=%b busy=%b done=%b, want cntr=7 idle",
                  bus.cntr_o, bus.tc_o, bus.busy_o, bus.done_o);
      end

      bus.load_val = 8'd4; bus.start = 1'b1;
      for (int e = 0; e < 3; e++) begin
         step();
         bus.start = 1'b0;
      end
      bus.load_val = 8'd7; bus.start = 1'b1;
      for (int e = 0; e < 10; e++) begin
         step();
         bus.start = 1'b0;
         vectors++;
         if ({bus.cntr_o, bus.tc_o, bus.busy_o, bus.done_o} !== {W'(m_shown), m_tc, m_run, m_done}) begin
            miscompares++;
            $display("FAIL restart E%0d: got cntr=%0d tc=%b busy=%b done=%b, want cntr=%0d tc=%b busy=%b done=%b",
                     e, bus.cntr_o, bus.tc_o, bus.busy_o, bus.done_o, m_shown, m_tc, m_run, m_done);
         end
      end
      bus.load_val = 8'd1; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      vectors++;
      if ({bus.cntr_o, bus.tc_o, bus.busy_o, bus.done_o} !== {8'd1, 3'b010}) begin
         miscompares++;
         $display("FAIL start_in_done: got cntr=%0d tc=%b busy=%b done=%b, want cntr=1 busy",
                  bus.cntr_o, bus.tc_o, bus.busy_o, bus.done_o);
      end
      bus.stop = 1'b1; step(); bus.stop = 1'b0;
   endtask

   task automatic test_async_reset();
      bus.load_val = 8'd6; bus.periodic = 1'b1; bus.en = 1'b1; bus.start = 1'b1;
      for (int e = 0; e < 4; e++) begin
         step();
         bus.start = 1'b0;
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      model_reset();
      vectors++;
      if ({bus.cntr_o, bus.tc_o, bus.busy_o, bus.done_o} !== {8'd0, 3'b000}) begin
         miscompares++;
         $display("FAIL async_reset: got cntr=%0d tc=%b busy=%b done=%b before next edge, want all zero",
                  bus.cntr_o, bus.tc_o, bus.busy_o, bus.done_o);
      end
      @(negedge clk);
      rst = 1'b0;
      bus.load_val = 8'd2; bus.periodic = 1'b0; bus.start = 1'b1;
      for (int e = 0; e < 5; e++) begin
         step();
         bus.start = 1'b0;
         vectors++;
         if ({bus.cntr_o, bus.tc_o, bus.busy_o, bus.done_o} !== {W'(m_shown), m_tc, m_run, m_done}) begin
            miscompares++;
            $display("FAIL post_reset E%0d: got cntr=%0d tc=%b busy=%b done=%b, want cntr=%0d tc=%b busy=%b done=%b",
                     e, bus.cntr_o, bus.tc_o, bus.busy_o, bus.done_o, m_shown, m_tc, m_run, m_done);
         end
      end
   endtask

   task automatic test_random();
      for (int e = 0; e < 600; e++) begin
         bus.en       = ($urandom_range(0, 7) != 0);
         bus.start    = ($urandom_range(0, 14) == 0);
         bus.stop     = ($urandom_range(0, 29) == 0);
         bus.periodic = $urandom_range(0, 1) == 1;
         bus.load_val = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 6));
         step();
         vectors++;
         if ({bus.cntr_o, bus.tc_o, bus.busy_o, bus.done_o} !== {W'(m_shown), m_tc, m_run, m_done}) begin
            miscompares++;
            $display("FAIL random #%0d: got cntr=%0d tc=%b busy=%b done=%b, want cntr=%0d tc=%b busy=%b done=%b",
                     e, bus.cntr_o, bus.tc_o, bus.busy_o, bus.done_o, m_shown, m_tc, m_run, m_done);
         end
      end
      set_idle_inputs();
   endtask

   initial begin
      test_reset();
      test_one_shot();
      test_periodic();
      test_pause();
      test_edges();
      test_control();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
